// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - function codes, condition-code layout and controller states for the shared ALU
package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   localparam int ZF = 2;
   localparam int SF = 1;
   localparam int OF = 0;

   localparam logic [2:0] CC_RESET = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational add/sub/and/xor with Y86-64 style {ZF,SF,OF} flags
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [1:0]       fn_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] r_o,
   output logic [2:0]       flags_o
);

   logic [WIDTH-1:0] res;
   logic             ovf;

   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (fn_i)
         ALU_ADD: begin
            res = a_i + b_i;
            ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
         end
         // Subtraction is B minus A, so overflow is judged against b's sign.
         ALU_SUB: begin
            res = b_i - a_i;
            ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != b_i[WIDTH-1]);
         end
         ALU_AND: res = a_i & b_i;
         default: res = a_i ^ b_i;
      endcase
   end

   always_comb begin
      flags_o     = '0;
      flags_o[ZF] = (res == '0);
      flags_o[SF] = res[WIDTH-1];
      flags_o[OF] = ovf;
   end

   assign r_o = res;

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one ALU between NREQ requesters with a cc register
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREQ  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_fn,
   input  logic [NREQ-1:0]       req_setcc,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [2:0]            cc
);

   localparam int IDW = $clog2(NREQ);

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   gnt_id, cand;
   logic             gnt_found, accept;
   logic [1:0]       fn_q;
   logic             setcc_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [2:0]       cc_q;
   logic [WIDTH-1:0] alu_r;
   logic [2:0]       alu_flags;

   // Search begins one past the last winner so every requester gets a turn.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_q) + k) % NREQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      accept    = 1'b0;
      req_ready = '0;
      rsp_valid = '0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_found) begin
               req_ready[gnt_id] = 1'b1;
               accept            = 1'b1;
               last_d            = gnt_id;
               id_d              = gnt_id;
               state_d           = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            rsp_valid[id_q] = 1'b1;
            if (rsp_ready[id_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= IDW'(NREQ - 1);
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fn_q       <= ALU_ADD;
         setcc_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_data_q <= '0;
         cc_q       <= CC_RESET;
      end else begin
         if (accept) begin
            fn_q    <= req_fn[int'(gnt_id)*2 +: 2];
            setcc_q <= req_setcc[gnt_id];
            a_q     <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
            b_q     <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
         end
         if (state_q == ST_EXEC) begin
            rsp_data_q <= alu_r;
            if (setcc_q) begin
               cc_q <= alu_flags;
            end
         end
      end
   end

   alu_core #(.WIDTH(WIDTH)) u_alu_core (
      .fn_i    (fn_q),
      .a_i     (a_q),
      .b_i     (b_q),
      .r_o     (alu_r),
      .flags_o (alu_flags)
   );

   assign rsp_data = rsp_data_q;
   assign cc       = cc_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - randomized bench for alu_share_ctrl against a transaction-level model
`timescale 1ns/1ps
module tb_alu_share_ctrl;

   localparam int W = 64;
   localparam int N = 2;
   localparam logic [1:0] F_ADD = 2'd0;
   localparam logic [1:0] F_SUB = 2'd1;
   localparam logic [1:0] F_AND = 2'd2;
   localparam logic [1:0] F_XOR = 2'd3;

   typedef struct {
      logic [1:0]   fn;
      logic         setcc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           has_exp;
      logic [W-1:0] exp_r;
      logic [2:0]   exp_cc;
   } op_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [2*N-1:0] req_fn;
   logic [N-1:0]   req_setcc;
   logic [W*N-1:0] req_a;
   logic [W*N-1:0] req_b;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [W-1:0]   rsp_data;
   logic [2:0]     cc;

   always #5 clk = ~clk;

   alu_share_ctrl #(.WIDTH(W), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_fn    (req_fn),
      .req_setcc (req_setcc),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .cc        (cc)
   );

   int n_chk = 0;
   int n_err = 0;

   op_t  q0[$];
   op_t  q1[$];
   int   glog[$];
   int   owner = -1;
   int   ka = 0;
   int   cyc = 0;
   int   last = N - 1;
   int   acc_g = -1;
   bit   hs = 1'b0;
   bit   rand_mode = 1'b0;
   bit   bp = 1'b0;
   op_t  cur;
   logic [W-1:0] exp_r;
   logic [2:0]   exp_fl;
   logic [2:0]   exp_cc = 3'b100;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Exact signed arithmetic in W+1 bits; overflow means the wrapped result lost information.
   function automatic void ref_op(input op_t o, output logic [W-1:0] r, output logic [2:0] fl);
      logic signed [W:0] sa, sb, exact;
      sa    = $signed({o.a[W-1], o.a});
      sb    = $signed({o.b[W-1], o.b});
      exact = '0;
      case (o.fn)
         F_ADD: begin r = o.a + o.b; exact = sa + sb; end
         F_SUB: begin r = o.b - o.a; exact = sb - sa; end
         F_AND: r = o.a & o.b;
         default: r = o.a ^ o.b;
      endcase
      fl[2] = (r == '0);
      fl[1] = ($signed(r) < 0);
      fl[0] = (o.fn == F_ADD || o.fn == F_SUB) && (exact != $signed({r[W-1], r}));
   endfunction

   function automatic op_t mk(input logic [1:0] fn, input logic setcc, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit he, input logic [W-1:0] er,
                              input logic [2:0] ec);
      op_t o;
      o.fn = fn; o.setcc = setcc; o.a = a; o.b = b;
      o.has_exp = he; o.exp_r = er; o.exp_cc = ec;
      return o;
   endfunction

   function automatic logic [W-1:0] rnd64();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 64'h7FFF_FFFF_FFFF_FFFF;
         2: return 64'h8000_0000_0000_0000;
         3: return '1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic op_t rnd_op();
      return mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'b0, '0, '0);
   endfunction

   task automatic step();
      logic [N-1:0] v, exp_rv, exp_rr, sh;
      bit vis;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) owner = -1;
      if (acc_g >= 0) begin
         owner = acc_g;
         ka    = cyc;
         last  = acc_g;
         glog.push_back(acc_g);
         if (acc_g == 0) cur = q0.pop_front();
         else cur = q1.pop_front();
         ref_op(cur, exp_r, exp_fl);
      end
      if (owner >= 0 && cyc == ka + 1 && cur.setcc) exp_cc = exp_fl;
      vis    = (owner >= 0) && (cyc >= ka + 1);
      exp_rv = '0;
      if (vis) exp_rv = N'(1) << owner;
      chk("rsp_valid", W'(rsp_valid), W'(exp_rv));
      if (vis) chk("rsp_data", rsp_data, exp_r);
      if (vis && cyc == ka + 1 && cur.has_exp) begin
         chk("dir_result", rsp_data, cur.exp_r);
         chk("dir_cc", W'(cc), W'(cur.exp_cc));
      end
      chk("cc", W'(cc), W'(exp_cc));

      if (rand_mode) begin
         if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rnd_op());
         if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rnd_op());
      end
      v = '0;
      if (q0.size() > 0) begin
         v[0] = 1'b1; req_fn[1:0] = q0[0].fn; req_setcc[0] = q0[0].setcc;
         req_a[W-1:0] = q0[0].a; req_b[W-1:0] = q0[0].b;
      end
      if (q1.size() > 0) begin
         v[1] = 1'b1; req_fn[3:2] = q1[0].fn; req_setcc[1] = q1[0].setcc;
         req_a[2*W-1:W] = q1[0].a; req_b[2*W-1:W] = q1[0].b;
      end
      if (rand_mode && $urandom_range(0, 7) == 0) begin
         if ($urandom_range(0, 1) == 0) v[0] = 1'b0;
         else v[1] = 1'b0;
      end
      req_valid = v;
      if (bp) rsp_ready = '0;
      else if (rand_mode) rsp_ready = N'($urandom);
      else rsp_ready = '1;
      #1;
      acc_g  = -1;
      exp_rr = '0;
      if (owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c  = (last + k) % N;
            sh = v >> c;
            if (acc_g < 0 && sh[0]) acc_g = c;
         end
      end
      if (acc_g >= 0) exp_rr = N'(1) << acc_g;
      chk("req_ready", W'(req_ready), W'(exp_rr));
      hs = 1'b0;
      if (vis) begin
         sh = rsp_ready >> owner;
         hs = sh[0];
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || owner >= 0 || acc_g >= 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", W'(n >= budget), '0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; req_valid = '0; req_fn = '0; req_setcc = '0;
      req_a = '0; req_b = '0; rsp_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", W'(req_ready), '0);
      chk("reset_rsp_valid", W'(rsp_valid), '0);
      chk("reset_rsp_data", rsp_data, '0);
      chk("reset_cc", W'(cc), W'(3'b100));
      rst_n = 1'b1;

      // contention straight out of reset: requester 0 first, then alternating
      glog.delete();
      q0.push_back(mk(F_ADD, 1'b0, 64'd10, 64'd20, 1'b1, 64'd30, 3'b100));
      q0.push_back(mk(F_SUB, 1'b0, 64'd3, 64'd9, 1'b1, 64'd6, 3'b100));
      q1.push_back(mk(F_XOR, 1'b0, 64'hFF, 64'h0F, 1'b1, 64'hF0, 3'b100));
      q1.push_back(mk(F_AND, 1'b0, 64'hFF, 64'h0F, 1'b1, 64'h0F, 3'b100));
      drain(100);
      chk("grant_count", W'(glog.size()), 64'd4);
      foreach (glog[i]) chk("grant_order", W'(glog[i]), W'(i % 2));

      q0.push_back(mk(F_XOR, 1'b1, 64'd19, 64'd23, 1'b1, 64'd4, 3'b000));
      drain(50);
      q1.push_back(mk(F_XOR, 1'b1, 64'd25, 64'd72, 1'b1, 64'd81, 3'b000));
      q1.push_back(mk(F_XOR, 1'b1, -64'sd12, -64'sd13, 1'b1, 64'd7, 3'b000));
      drain(50);

      q0.push_back(mk(F_SUB, 1'b1, 64'd5, 64'd5, 1'b1, 64'd0, 3'b100));
      q0.push_back(mk(F_ADD, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
                      64'h8000_0000_0000_0000, 3'b011));
      q0.push_back(mk(F_AND, 1'b0, 64'hF0, 64'h0F, 1'b1, 64'd0, 3'b011));
      drain(50);

      // response backpressure with requester 1 waiting
      bp = 1'b1;
      q0.push_back(mk(F_ADD, 1'b0, 64'd3, 64'd4, 1'b1, 64'd7, 3'b011));
      n = 0;
      while (!(owner == 0 && cyc >= ka + 1) && n < 20) begin
         step();
         n++;
      end
      chk("bp_reach_resp", W'(n >= 20), '0);
      q1.push_back(mk(F_SUB, 1'b0, 64'd1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011));
      repeat (5) step();
      bp = 1'b0;
      drain(50);

      rand_mode = 1'b1;
      repeat (3000) step();
      rand_mode = 1'b0;
      drain(200);

      // reset while an op with setcc is in EXEC
      q0.push_back(mk(F_ADD, 1'b1, 64'd1, 64'd1, 1'b0, '0, '0));
      n = 0;
      while (!(owner == 0 && cyc == ka) && n < 20) begin
         step();
         n++;
      end
      chk("exec_reach", W'(n >= 20), '0);
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      chk("midrst_rsp_valid", W'(rsp_valid), '0);
      chk("midrst_cc", W'(cc), W'(3'b100));
      chk("midrst_req_ready", W'(req_ready), '0);
      @(posedge clk);
      #1;
      chk("midrst_rsp_data", rsp_data, '0);
      chk("midrst_cc_hold", W'(cc), W'(3'b100));
      q0.delete(); q1.delete(); glog.delete();
      owner = -1; acc_g = -1; hs = 1'b0; last = N - 1; exp_cc = 3'b100;
      rst_n = 1'b1;
      q0.push_back(mk(F_XOR, 1'b0, 64'd6, 64'd3, 1'b1, 64'd5, 3'b100));
      q1.push_back(mk(F_ADD, 1'b0, 64'd6, 64'd3, 1'b1, 64'd9, 3'b100));
      drain(50);
      chk("post_reset_grants", W'(glog.size()), 64'd2);
      if (glog.size() > 0) chk("post_reset_first", W'(glog[0]), '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
